shift_register_unload: RTL



---
 rtl/shift_register_unload_pkg.sv | 24 ++
 rtl/shift_register_unload_counter.sv | 42 ++++
 rtl/shift_register_unload.sv | 91 +++++++++
 3 files changed

// File: rtl/shift_register_unload_pkg.sv
// Shared definitions for the parallel-in, serial-out unloader.
// Holds the FSM encoding and the counter-width helper.
package shift_register_unload_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A Depth of 1 still needs a one-bit counter.
    function automatic int cnt_width(input int depth);
        return (clog2(depth) < 1) ? 1 : clog2(depth);
    endfunction

endpackage

// File: rtl/shift_register_unload_counter.sv
// Element index within the word being unloaded; clear wins over increment.
// Zero latency on is_last_o, no backpressure of its own (inc_i is pre-gated by stall).
module unload_counter
    import shift_register_unload_pkg::*;
#(
    parameter int Depth    = 4,
    parameter int CntWidth = cnt_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                clr_i,
    input  logic                inc_i,
    output logic [CntWidth-1:0] cnt_o,
    output logic                is_last_o
);

    localparam logic [CntWidth-1:0] LastCnt = CntWidth'(Depth - 1);

    logic [CntWidth-1:0] cnt_q;
    logic [CntWidth-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != LastCnt)) begin
            cnt_d = cnt_q + CntWidth'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o     = cnt_q;
    assign is_last_o = (cnt_q == LastCnt);

endmodule

// File: rtl/shift_register_unload.sv
// Wide word in through valid/ready, elements out top-first one per unstalled cycle.
// Latency 1 from load edge to first element; stall freezes everything and drops load_ready.
module shift_register_unload
    import shift_register_unload_pkg::*;
#(
    parameter int DataWidth = 8,
    parameter int Depth     = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       stall,
    input  logic                       load_valid,
    output logic                       load_ready,
    input  logic [DataWidth*Depth-1:0] wdin,
    output logic [DataWidth-1:0]       dout,
    output logic                       dout_valid,
    output logic                       dout_last,
    output logic                       busy
);

    localparam int CntWidth = cnt_width(Depth);
    localparam int WordW    = DataWidth * Depth;

    state_e              state_q;
    state_e              state_d;
    logic [WordW-1:0]    data_q;
    logic [WordW-1:0]    data_d;
    logic [CntWidth-1:0] cnt;
    logic                is_last;
    logic                in_shift;
    logic                load_fire;
    logic                cnt_inc;
    logic                cnt_clr;

    assign in_shift  = (state_q == SHIFT);
    assign load_ready = ~stall & (~in_shift | is_last);
    assign load_fire = load_valid & load_ready;
    assign cnt_inc   = in_shift & ~stall;
    // Finishing a word also parks the counter at zero so IDLE never holds a stale index.
    assign cnt_clr   = load_fire | (cnt_inc & is_last);

    unload_counter #(
        .Depth    (Depth),
        .CntWidth (CntWidth)
    ) u_unload_counter (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .cnt_o     (cnt),
        .is_last_o (is_last)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (!stall) begin
            if (load_fire) begin
                data_d  = wdin;
                state_d = SHIFT;
            end else if (in_shift) begin
                if (is_last) begin
                    state_d = IDLE;
                    data_d  = '0;
                end else begin
                    // Element k takes element k-1; zeros fill from the bottom.
                    data_d = data_q << DataWidth;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    assign dout       = data_q[WordW-1 -: DataWidth];
    assign dout_valid = in_shift;
    assign dout_last  = in_shift & is_last;
    assign busy       = in_shift;

    cnt_in_range: assert property (@(posedge clk) disable iff (rst)
        cnt <= CntWidth'(Depth - 1));

endmodule
